// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: command, config and ready/enable handshake bundle for capture_sequencer.
interface capture_sequencer_if #(
   parameter int DEC_WIDTH = 22,
   parameter int FRAME_W   = 16,
   parameter int TO_W      = 32
);
   logic                 start_i;
   logic                 abort_i;
   logic [DEC_WIDTH-1:0] decimation_code_i;
   logic [FRAME_W-1:0]   num_frames_i;
   logic [TO_W-1:0]      timeout_i;
   logic                 bram_ready_i;
   logic                 dma_ready_i;
   logic                 bram_enable_o;
   logic                 dma_enable_o;
   logic [DEC_WIDTH-1:0] decimation_code_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 fault_o;
   logic [FRAME_W-1:0]   frames_done_o;
   logic [2:0]           state_o;
   modport master (
      output start_i, abort_i, decimation_code_i, num_frames_i, timeout_i, bram_ready_i, dma_ready_i,
      input  bram_enable_o, dma_enable_o, decimation_code_o, busy_o, done_o, fault_o, frames_done_o, state_o
   );
   modport slave (
      input  start_i, abort_i, decimation_code_i, num_frames_i, timeout_i, bram_ready_i, dma_ready_i,
      output bram_enable_o, dma_enable_o, decimation_code_o, busy_o, done_o, fault_o, frames_done_o, state_o
   );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: runs BRAM fill then DMA drain for a programmed number of frames.
// Define CAPTURE_SEQ_WATCHDOG_EN to add a per-phase watchdog with a sticky FAULT state.
module capture_sequencer #(
   parameter int DEC_WIDTH   = 22,
   parameter int FRAME_W     = 16,
   parameter int TO_W        = 32,
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst_n,
   capture_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, DRAIN = 3'd2, GAP = 3'd3, FAULT = 3'd4} state_t;
   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] bram_sync, dma_sync;
   logic                   bram_q, dma_q, bram_rise, dma_rise;
   logic                   accept, last, done_nx, timeout_hit;
   logic [FRAME_W-1:0]     target;
   assign bram_rise = bram_sync[SYNC_STAGES-1] & ~bram_q;
   assign dma_rise  = dma_sync[SYNC_STAGES-1] & ~dma_q;
   assign accept    = state == IDLE && bus.start_i && !bus.abort_i;
   assign last      = {1'b0, bus.frames_done_o} + (FRAME_W+1)'(1) == {1'b0, target};
   assign bus.bram_enable_o = state == FILL;
   assign bus.dma_enable_o  = state == DRAIN;
   assign bus.busy_o        = state != IDLE;
   assign bus.state_o       = state;
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      case (state)
         IDLE:  if (accept) state_nx = FILL;
         FILL:  if (bram_rise) state_nx = DRAIN;
                else if (timeout_hit) state_nx = FAULT;
         DRAIN: if (dma_rise) begin
                   state_nx = last ? IDLE : GAP;
                   done_nx  = last;
                end else if (timeout_hit) state_nx = FAULT;
         GAP:   state_nx = FILL;
         default: state_nx = state;
      endcase
      // abort outranks any ready edge or timeout seen in the same cycle
      if (bus.abort_i && state != IDLE) begin
         state_nx = IDLE;
         done_nx  = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         bram_sync             <= '0;
         dma_sync              <= '0;
         bram_q                <= 1'b0;
         dma_q                 <= 1'b0;
         target                <= '0;
         bus.decimation_code_o <= '0;
         bus.frames_done_o     <= '0;
         bus.done_o            <= 1'b0;
      end else begin
         state      <= state_nx;
         bram_sync  <= {bram_sync[SYNC_STAGES-2:0], bus.bram_ready_i};
         dma_sync   <= {dma_sync[SYNC_STAGES-2:0], bus.dma_ready_i};
         bram_q     <= bram_sync[SYNC_STAGES-1];
         dma_q      <= dma_sync[SYNC_STAGES-1];
         bus.done_o <= done_nx;
         if (accept) begin
            bus.decimation_code_o <= bus.decimation_code_i;
            target                <= bus.num_frames_i == '0 ? FRAME_W'(1) : bus.num_frames_i;
            bus.frames_done_o     <= '0;
         end else if (state == DRAIN && dma_rise && !bus.abort_i)
            bus.frames_done_o <= &bus.frames_done_o ? bus.frames_done_o : bus.frames_done_o + FRAME_W'(1);
      end
   end
`ifdef CAPTURE_SEQ_WATCHDOG_EN
   logic [TO_W-1:0] wd_cnt;
   assign timeout_hit = bus.timeout_i != '0 && {1'b0, wd_cnt} + (TO_W+1)'(1) == {1'b0, bus.timeout_i};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt      <= '0;
         bus.fault_o <= 1'b0;
      end else begin
         wd_cnt <= state_nx != state ? '0 : wd_cnt + TO_W'(1);
         if (state_nx == FAULT) bus.fault_o <= 1'b1;
         else if (accept) bus.fault_o <= 1'b0;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^bus.timeout_i;
   assign timeout_hit    = 1'b0;
   assign bus.fault_o    = 1'b0;
`endif
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: table-driven frame runs plus abort, reset and watchdog sequences, scoreboarded frame counts.
module tb_capture_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   gap_len = 0;
   logic prev_done = 1'b0;
   logic [15:0] prev_frames = '0;
   logic [15:0] sb[$];
   typedef struct {
      logic [15:0] num;
      logic [21:0] dec;
      bit          stale;
      int          frames;
   } vec_t;
   vec_t tbl[4];
   capture_sequencer_if #(.DEC_WIDTH(22), .FRAME_W(16), .TO_W(32)) bus();
   capture_sequencer #(.DEC_WIDTH(22), .FRAME_W(16), .TO_W(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // checks that hold every cycle: enable exclusion, single-cycle done, one-cycle GAP, scoreboarded frame count
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.busy_o) chk("excl", {31'b0, bus.bram_enable_o & bus.dma_enable_o}, 0);
         if (bus.done_o) begin
            done_cnt++;
            chk("done_pulse", {31'b0, prev_done}, 0);
         end
         if (bus.state_o == 3'd3) gap_len++;
         else begin
            if (gap_len != 0) begin
               chk("gap_len", gap_len, 1);
               chk("gap_to_fill", {29'b0, bus.state_o}, 1);
            end
            gap_len = 0;
         end
         if (bus.frames_done_o != prev_frames && bus.frames_done_o != 0) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL frames_unexpected: got %0d expected no change", bus.frames_done_o);
            end else chk("frames_sb", {16'b0, bus.frames_done_o}, {16'b0, sb.pop_front()});
         end
         prev_done   = bus.done_o;
         prev_frames = bus.frames_done_o;
      end else begin
         prev_done   = 1'b0;
         prev_frames = '0;
         gap_len     = 0;
      end
   end
   task automatic start_run(input logic [15:0] num, input logic [21:0] dec);
      bus.num_frames_i      = num;
      bus.decimation_code_i = dec;
      bus.start_i           = 1'b1;
      step();
      bus.start_i           = 1'b0;
      bus.num_frames_i      = ~num;
      bus.decimation_code_i = ~dec;
   endtask
   task automatic fill_phase();
      bus.bram_ready_i = 1'b0;
      repeat (3) step();
      bus.bram_ready_i = 1'b1;
      repeat (2) step();
      chk("fill_hold", {29'b0, bus.state_o}, 1);
      step();
      chk("drain_en", {30'b0, bus.bram_enable_o, bus.dma_enable_o}, 2'b01);
   endtask
   task automatic drain_prefix(input logic [15:0] exp_frames);
      bus.dma_ready_i = 1'b0;
      repeat (3) step();
      sb.push_back(exp_frames);
      bus.dma_ready_i = 1'b1;
      repeat (2) step();
      chk("drain_hold", {29'b0, bus.state_o}, 2);
   endtask
   task automatic run_vec(input vec_t v);
      int d0;
      bus.bram_ready_i = v.stale;
      bus.dma_ready_i  = 1'b0;
      repeat (4) step();
      d0 = done_cnt;
      start_run(v.num, v.dec);
      chk("start_fill", {29'b0, bus.state_o}, 1);
      chk("start_en", {30'b0, bus.bram_enable_o, bus.dma_enable_o}, 2'b10);
      chk("start_frames", {16'b0, bus.frames_done_o}, 0);
      for (int f = 0; f < v.frames; f++) begin
         if (v.stale && f == 0) begin
            repeat (6) step();
            chk("stale_hold", {29'b0, bus.state_o}, 1);
         end
         fill_phase();
         chk("dec_run", {10'b0, bus.decimation_code_o}, {10'b0, v.dec});
         drain_prefix(16'(f + 1));
         step();
         if (f == v.frames - 1) begin
            chk("end_state", {29'b0, bus.state_o}, 0);
            chk("end_done", {31'b0, bus.done_o}, 1);
         end else chk("gap_state", {28'b0, bus.state_o, bus.bram_enable_o | bus.dma_enable_o}, 6);
      end
      step();
      chk("done_low", {31'b0, bus.done_o}, 0);
      chk("done_count", done_cnt - d0, 1);
      chk("frames_final", {16'b0, bus.frames_done_o}, v.frames);
      chk("dec_final", {10'b0, bus.decimation_code_o}, {10'b0, v.dec});
      chk("sb_drained", sb.size(), 0);
   endtask
   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      int d0;
      tbl[0] = '{16'd1, 22'h5, 1'b0, 1};
      tbl[1] = '{16'd3, 22'h2A5A5, 1'b0, 3};
      tbl[2] = '{16'd0, 22'h3FFFFF, 1'b1, 1};
      tbl[3] = '{16'd2, 22'h1, 1'b0, 2};
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.decimation_code_i = '0;
      bus.num_frames_i = '0;
      bus.timeout_i = '0;
      bus.bram_ready_i = 1'b0;
      bus.dma_ready_i = 1'b0;
      #3;
      chk("rst_outs", {26'b0, bus.bram_enable_o, bus.dma_enable_o, bus.busy_o, bus.done_o, bus.fault_o, bus.state_o[0]}, 0);
      chk("rst_frames", {16'b0, bus.frames_done_o}, 0);
      chk("rst_dec", {10'b0, bus.decimation_code_o}, 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("post_rst_state", {28'b0, bus.busy_o, bus.state_o}, 0);
      for (int i = 0; i < 4; i++) run_vec(tbl[i]);
      // start together with abort in IDLE is ignored
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      chk("start_abort_idle", {28'b0, bus.busy_o, bus.state_o}, 0);
      // abort in the same cycle as the internal dma edge of frame 2 of 4
      d0 = done_cnt;
      bus.bram_ready_i = 1'b0;
      bus.dma_ready_i = 1'b0;
      repeat (4) step();
      start_run(16'd4, 22'h7);
      bus.decimation_code_i = 22'h9;
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      chk("start_in_fill", {29'b0, bus.state_o}, 1);
      chk("dec_after_restart", {10'b0, bus.decimation_code_o}, 7);
      fill_phase();
      drain_prefix(16'd1);
      step();
      step();
      fill_phase();
      bus.dma_ready_i = 1'b0;
      repeat (3) step();
      bus.dma_ready_i = 1'b1;
      repeat (2) step();
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      chk("abort_state", {26'b0, bus.bram_enable_o, bus.dma_enable_o, bus.busy_o, bus.state_o}, 0);
      chk("abort_done", {31'b0, bus.done_o}, 0);
      chk("abort_frames", {16'b0, bus.frames_done_o}, 1);
      step();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_sb", sb.size(), 0);
`ifdef CAPTURE_SEQ_WATCHDOG_EN
      bus.timeout_i = 32'd100;
      bus.bram_ready_i = 1'b0;
      start_run(16'd1, 22'h3);
      repeat (99) step();
      chk("wd_pre", {29'b0, bus.state_o}, 1);
      step();
      chk("wd_fault", {26'b0, bus.fault_o, bus.busy_o, bus.bram_enable_o, bus.state_o}, 6'b110100);
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      chk("wd_start_ignored", {29'b0, bus.state_o}, 4);
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      chk("wd_abort", {28'b0, bus.fault_o, bus.state_o}, 8);
      bus.timeout_i = '0;
      start_run(16'd1, 22'h3);
      chk("wd_clear", {28'b0, bus.fault_o, bus.state_o}, 1);
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
`else
      bus.timeout_i = 32'd5;
      bus.bram_ready_i = 1'b0;
      start_run(16'd1, 22'h3);
      repeat (20) step();
      chk("no_wd", {28'b0, bus.fault_o, bus.state_o}, 1);
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      bus.timeout_i = '0;
`endif
      // asynchronous reset in the middle of FILL
      start_run(16'd2, 22'h11);
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_outs", {26'b0, bus.bram_enable_o, bus.dma_enable_o, bus.busy_o, bus.done_o, bus.fault_o, bus.state_o[0]}, 0);
      chk("async_rst_dec", {10'b0, bus.decimation_code_o}, 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("rst_release", {28'b0, bus.busy_o, bus.state_o}, 0);
      run_vec(tbl[1]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
